// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default sizes and Gray/binary pointer
// conversions used by both the read-side drain and the write-side full logic.
package fifo_pkg;

    localparam int ADDR_WIDTH_DEF = 3;
    localparam int DATA_WIDTH_DEF = 8;

    // Prefetch buffer occupancy, 0..2
    typedef logic [1:0] occ_t;

    // Gray to binary over a zero-extended 32-bit vector; callers truncate
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        for (int i = 0; i < 32; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    // Binary to Gray over a zero-extended 32-bit vector; callers truncate
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/fifo_rd_drain_if.sv
// Output word stream of the read-side drain.
// Handshake: a word moves on a rclk edge where dout_valid and dout_ready are
// both 1; once dout_valid is 1 it and dout stay stable until that transfer,
// and dout_valid never depends combinationally on dout_ready.
interface fifo_rd_drain_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic                  dout_ready;

    modport master (output dout, output dout_valid, input dout_ready);
    modport slave  (input dout, input dout_valid, output dout_ready);
endinterface

// File: rtl/sync_w2r.sv
// Multi-flop synchronizer carrying the Gray write pointer into rclk.
// Only a plain flop chain: Gray coding guarantees at most one bit changes.
module sync_w2r #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             rclk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    // Shift the pointer through the flop chain, clearing it on reset
    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/fifo_rd_drain.sv
// Read-domain drain of the async FIFO: synchronizes the write pointer,
// reports the registered fill level, and pops memory words into a 2-entry
// prefetch buffer that feeds a valid/ready output stream.
module fifo_rd_drain
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int AE_THRESH   = 1
) (
    input  logic                  rclk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH:0]   wptr,
    output logic [ADDR_WIDTH:0]   wptr_sync,
    input  logic [ADDR_WIDTH:0]   rptr,
    input  logic                  empty,
    output logic                  rinc,
    input  logic [DATA_WIDTH-1:0] rdata,
    fifo_rd_drain_if.master       stream,
    output logic [ADDR_WIDTH:0]   rd_level,
    output logic                  almost_empty
);

    localparam int PW = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [2];
    logic                  head;
    logic                  tail;
    occ_t                  occ;
    occ_t                  occ_next;
    logic                  push;
    logic                  pop;
    logic [PW-1:0]         wbin;
    logic [PW-1:0]         rbin;
    logic [PW-1:0]         level_next;

    sync_w2r #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_sync_w2r (
        .rclk  (rclk),
        .rst_n (rst_n),
        .d     (wptr),
        .q     (wptr_sync)
    );

    // Pop only while the buffer has room; dout_ready is deliberately not used
    // here so the pop request never waits on the downstream consumer.
    assign rinc = ~empty & (occ < 2'd2);
    assign push = rinc;
    assign pop  = stream.dout_valid & stream.dout_ready;

    assign stream.dout       = mem[head];
    assign stream.dout_valid = (occ != 2'd0);

    // Next occupancy from the push/pop combination
    always_comb begin
        occ_next = occ;
        case ({push, pop})
            2'b10:   occ_next = occ + 2'd1;
            2'b01:   occ_next = occ - 2'd1;
            default: occ_next = occ;
        endcase
    end

    // Prefetch buffer: capture rdata at the tail, retire from the head
    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            head   <= 1'b0;
            tail   <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                mem[tail] <= rdata;
                tail      <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            occ <= occ_next;
        end
    end

    // Pointer difference modulo 2**PW covers wrap of either pointer
    always_comb begin
        wbin       = PW'(gray2bin(32'(wptr_sync)));
        rbin       = PW'(gray2bin(32'(rptr)));
        level_next = wbin - rbin;
    end

    // Registered level and almost-empty flag, updated together
    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            rd_level     <= '0;
            almost_empty <= 1'b1;
        end else begin
            rd_level     <= level_next;
            almost_empty <= (level_next <= PW'(AE_THRESH));
        end
    end

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Directed bench for fifo_rd_drain with a behavioural FIFO-core model.
module tb_fifo_rd_drain;

    localparam int AW = 3;
    localparam int DW = 8;
    localparam int PW = AW + 1;

    logic          rclk = 1'b0;
    logic          rst_n = 1'b0;
    logic [PW-1:0] wptr = '0;
    logic [PW-1:0] wptr_sync;
    logic [PW-1:0] rptr = '0;
    logic          empty = 1'b1;
    logic          rinc;
    logic [DW-1:0] rdata = '0;
    logic [PW-1:0] rd_level;
    logic          almost_empty;

    fifo_rd_drain_if #(.DATA_WIDTH(DW)) stream ();

    fifo_rd_drain #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .SYNC_STAGES (2),
        .AE_THRESH   (1)
    ) dut (
        .rclk         (rclk),
        .rst_n        (rst_n),
        .wptr         (wptr),
        .wptr_sync    (wptr_sync),
        .rptr         (rptr),
        .empty        (empty),
        .rinc         (rinc),
        .rdata        (rdata),
        .stream       (stream),
        .rd_level     (rd_level),
        .almost_empty (almost_empty)
    );

    // Clock
    always #5 rclk = ~rclk;

    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] mem_q [$];
    logic [DW-1:0] exp_q [$];
    logic [PW-1:0] wcount = '0;
    logic [PW-1:0] rcount = '0;
    logic          pop_seen;

    function automatic logic [PW-1:0] to_gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // FIFO core model: pops on edges where rinc was high, registered empty
    always begin
        @(posedge rclk);
        pop_seen = rinc & rst_n;
        #1;
        if (pop_seen && mem_q.size() > 0) begin
            void'(mem_q.pop_front());
            rcount = rcount + 1'b1;
        end
        empty = (mem_q.size() == 0);
        rdata = empty ? 8'h00 : mem_q[0];
        rptr  = to_gray(rcount);
    end

    // Driver: write one word into the modelled FIFO
    task automatic push_word(input logic [DW-1:0] w);
        mem_q.push_back(w);
        exp_q.push_back(w);
        wcount = wcount + 1'b1;
        wptr   = to_gray(wcount);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stream.dout_ready = 1'b0;
        wptr = 4'b0110;
        repeat (3) @(negedge rclk);
        checks++; if (wptr_sync !== 4'b0000) begin errors++; $display("FAIL reset_wptr_sync: got %h expected 0", wptr_sync); end
        checks++; if (stream.dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid: got %b expected 0", stream.dout_valid); end
        checks++; if (stream.dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", stream.dout); end
        checks++; if (rd_level !== 4'd0) begin errors++; $display("FAIL reset_rd_level: got %0d expected 0", rd_level); end
        checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_almost_empty: got %b expected 1", almost_empty); end
        checks++; if (rinc !== 1'b0) begin errors++; $display("FAIL reset_rinc: got %b expected 0", rinc); end
        rst_n = 1'b1;
        @(negedge rclk);
        checks++; if (wptr_sync !== 4'b0000) begin errors++; $display("FAIL sync_one_edge: got %h expected 0", wptr_sync); end
        @(negedge rclk);
        checks++; if (wptr_sync !== 4'b0110) begin errors++; $display("FAIL sync_two_edges: got %h expected 6", wptr_sync); end
        wcount = '0;
        wptr = '0;
        repeat (4) @(negedge rclk);
    endtask

    task automatic test_single();
        logic [DW-1:0] exp;
        stream.dout_ready = 1'b1;
        @(negedge rclk);
        push_word(8'hA5);
        @(negedge rclk);
        checks++; if (rinc !== 1'b1) begin errors++; $display("FAIL single_rinc: got %b expected 1", rinc); end
        checks++; if (stream.dout_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b expected 0", stream.dout_valid); end
        @(negedge rclk);
        exp = exp_q.pop_front();
        checks++; if (stream.dout_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", stream.dout_valid); end
        checks++; if (stream.dout !== exp) begin errors++; $display("FAIL single_dout: got %h expected %h", stream.dout, exp); end
        checks++; if (rinc !== 1'b0) begin errors++; $display("FAIL single_rinc_off: got %b expected 0", rinc); end
        @(negedge rclk);
        checks++; if (stream.dout_valid !== 1'b0) begin errors++; $display("FAIL single_drained: got %b expected 0", stream.dout_valid); end
    endtask

    task automatic test_backpressure();
        int            pops;
        int            got;
        logic [DW-1:0] exp;
        stream.dout_ready = 1'b0;
        @(negedge rclk);
        push_word(8'h11); push_word(8'h22); push_word(8'h33); push_word(8'h44);
        pops = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge rclk);
            if (rinc === 1'b1) pops++;
            if (stream.dout_valid === 1'b1) begin
                checks++; if (stream.dout !== 8'h11) begin errors++; $display("FAIL bp_hold_dout: got %h expected 11", stream.dout); end
            end
        end
        checks++; if (pops !== 2) begin errors++; $display("FAIL bp_pop_count: got %0d expected 2", pops); end
        checks++; if (stream.dout_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b expected 1", stream.dout_valid); end
        stream.dout_ready = 1'b1;
        got = 0;
        for (int i = 0; i < 12; i++) begin
            if (stream.dout_valid === 1'b1) begin
                got++;
                if (exp_q.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL bp_extra_word: got %h expected none", stream.dout);
                end else begin
                    exp = exp_q.pop_front();
                    checks++; if (stream.dout !== exp) begin errors++; $display("FAIL bp_order: got %h expected %h", stream.dout, exp); end
                end
            end
            @(negedge rclk);
        end
        checks++; if (got !== 4) begin errors++; $display("FAIL bp_word_count: got %0d expected 4", got); end
    endtask

    task automatic test_streaming();
        int            run;
        int            max_run;
        logic [DW-1:0] exp;
        stream.dout_ready = 1'b1;
        @(negedge rclk);
        for (int i = 0; i < 8; i++) push_word(8'h80 + 8'(i));
        run = 0;
        max_run = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge rclk);
            if (stream.dout_valid === 1'b1) begin
                run++;
                if (run > max_run) max_run = run;
                if (exp_q.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL stream_extra_word: got %h expected none", stream.dout);
                end else begin
                    exp = exp_q.pop_front();
                    checks++; if (stream.dout !== exp) begin errors++; $display("FAIL stream_order: got %h expected %h", stream.dout, exp); end
                end
            end else begin
                run = 0;
            end
        end
        checks++; if (max_run !== 8) begin errors++; $display("FAIL stream_run: got %0d expected 8", max_run); end
    endtask

    task automatic test_level();
        wcount = 4'd5; wptr = to_gray(wcount); rcount = 4'd2;
        repeat (5) @(negedge rclk);
        checks++; if (wptr_sync !== 4'b0111) begin errors++; $display("FAIL level_sync: got %h expected 7", wptr_sync); end
        checks++; if (rd_level !== 4'd3) begin errors++; $display("FAIL level_3: got %0d expected 3", rd_level); end
        checks++; if (almost_empty !== 1'b0) begin errors++; $display("FAIL level_3_ae: got %b expected 0", almost_empty); end
        wcount = 4'd1; wptr = to_gray(wcount); rcount = 4'd15;
        repeat (5) @(negedge rclk);
        checks++; if (rd_level !== 4'd2) begin errors++; $display("FAIL level_wrap: got %0d expected 2", rd_level); end
        checks++; if (almost_empty !== 1'b0) begin errors++; $display("FAIL level_wrap_ae: got %b expected 0", almost_empty); end
        wcount = 4'd7; wptr = to_gray(wcount); rcount = 4'd6;
        repeat (5) @(negedge rclk);
        checks++; if (rd_level !== 4'd1) begin errors++; $display("FAIL level_1: got %0d expected 1", rd_level); end
        checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL level_1_ae: got %b expected 1", almost_empty); end
        wcount = 4'd8; wptr = to_gray(wcount); rcount = 4'd0;
        repeat (5) @(negedge rclk);
        checks++; if (rd_level !== 4'd8) begin errors++; $display("FAIL level_full: got %0d expected 8", rd_level); end
        wcount = 4'd9; wptr = to_gray(wcount); rcount = 4'd9;
        repeat (5) @(negedge rclk);
        checks++; if (rd_level !== 4'd0) begin errors++; $display("FAIL level_equal: got %0d expected 0", rd_level); end
        checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL level_equal_ae: got %b expected 1", almost_empty); end
        wcount = '0; wptr = '0; rcount = '0;
        repeat (5) @(negedge rclk);
    endtask

    task automatic test_reset_mid();
        int            got;
        logic [DW-1:0] exp;
        stream.dout_ready = 1'b0;
        @(negedge rclk);
        push_word(8'h55); push_word(8'h66); push_word(8'h77); push_word(8'h88);
        repeat (5) @(negedge rclk);
        checks++; if (stream.dout !== 8'h55) begin errors++; $display("FAIL mid_pre_dout: got %h expected 55", stream.dout); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (stream.dout_valid !== 1'b0) begin errors++; $display("FAIL mid_valid_cleared: got %b expected 0", stream.dout_valid); end
        checks++; if (stream.dout !== 8'h00) begin errors++; $display("FAIL mid_dout_cleared: got %h expected 00", stream.dout); end
        @(negedge rclk);
        rst_n = 1'b1;
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        stream.dout_ready = 1'b1;
        got = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge rclk);
            if (stream.dout_valid === 1'b1) begin
                got++;
                if (exp_q.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL mid_extra_word: got %h expected none", stream.dout);
                end else begin
                    exp = exp_q.pop_front();
                    checks++; if (stream.dout !== exp) begin errors++; $display("FAIL mid_order: got %h expected %h", stream.dout, exp); end
                end
            end
        end
        checks++; if (got !== 2) begin errors++; $display("FAIL mid_word_count: got %0d expected 2", got); end
    endtask

    initial begin
        stream.dout_ready = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_streaming();
        test_level();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
